// File: rtl/stored_byte_reader_pkg.sv
// Shared definitions for the stored-byte read path: controller state encoding
// and the default bank geometry also used by the storage bank itself.
package stored_byte_reader_pkg;

  localparam int DEF_NUM_SLOTS  = 4;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/stored_byte_reader_slot_counter.sv
// Slot index for one scan pass: cleared at pass start/end, stepped after each
// accepted byte, and never advanced past the last slot.
module stored_byte_reader_slot_counter
  import stored_byte_reader_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] count_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_SLOTS - 1);

  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] count_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Saturating at the last slot keeps a stray increment from wrapping mid-pass.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !last_o) begin
      count_d = count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_IDX);

endmodule

// File: rtl/stored_byte_reader.sv
// Walks the storage bank slot by slot and hands each stored byte downstream
// over a valid/ready handshake, pulsing done once per completed pass.
module stored_byte_reader
  import stored_byte_reader_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_slot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic [ADDR_WIDTH-1:0] out_slot_q;
  logic [ADDR_WIDTH-1:0] out_slot_d;

  logic                  slot_clear;
  logic                  slot_inc;
  logic [ADDR_WIDTH-1:0] slot_count;
  logic                  slot_last;

  stored_byte_reader_slot_counter #(
    .NUM_SLOTS  (NUM_SLOTS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_slot_counter (
    .clock   (clock),
    .resetn  (resetn),
    .clear_i (slot_clear),
    .inc_i   (slot_inc),
    .count_o (slot_count),
    .last_o  (slot_last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      out_data_q <= '0;
      out_slot_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      out_data_q <= out_data_d;
      out_slot_q <= out_slot_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_clear = 1'b0;
    slot_inc   = 1'b0;
    rd_addr_d  = rd_addr_q;
    out_data_d = out_data_q;
    out_slot_d = out_slot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          slot_clear = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_addr_d = slot_count;
        state_d   = ST_CAPTURE;
      end
      // The bank answers one cycle after rd_en, so the byte is taken here only.
      ST_CAPTURE: begin
        out_data_d = rd_data;
        out_slot_d = slot_count;
        state_d    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (slot_last) begin
            state_d = ST_FINISH;
          end else begin
            slot_inc = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        slot_clear = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so an async reset clears
  // them at once; rd_addr shows the live slot in FETCH and holds otherwise.
  assign rd_addr   = rd_addr_d;
  assign rd_en     = (state_q == ST_FETCH);
  assign out_valid = (state_q == ST_PRESENT);
  assign done      = (state_q == ST_FINISH);
  assign busy      = state_is_busy(state_q);
  assign out_data  = out_data_q;
  assign out_slot  = out_slot_q;

endmodule

// File: tb/tb_stored_byte_reader.sv
// Directed bench for stored_byte_reader with a small storage-bank model that
// answers one cycle after rd_en and drives filler data otherwise.
module tb_stored_byte_reader;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [1:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic [1:0] out_slot;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [7:0] mem [4];

  int vectors;
  int miscompares;
  int cyc;
  int rd_q[$];
  int rdi_q[$];
  int xs_q[$];
  int xd_q[$];
  int xi_q[$];
  int dn_q[$];

  stored_byte_reader dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_slot  (out_slot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    rd_data <= rd_en ? mem[rd_addr] : 8'hA5;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  task automatic clear_log();
    cyc = 0;
    rd_q.delete();
    rdi_q.delete();
    xs_q.delete();
    xd_q.delete();
    xi_q.delete();
    dn_q.delete();
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      if (rd_en) begin
        rd_q.push_back(int'(rd_addr));
        rdi_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        xs_q.push_back(int'(out_slot));
        xd_q.push_back(int'(out_data));
        xi_q.push_back(cyc);
      end
      if (done) dn_q.push_back(cyc);
      cyc++;
      tick();
    end
  endtask

  task automatic load_bank(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    mem[0] = b0;
    mem[1] = b1;
    mem[2] = b2;
    mem[3] = b3;
  endtask

  initial begin
    int exp_d [4];
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    start       = 1'b0;
    out_ready   = 1'b1;
    load_bank(8'h11, 8'h22, 8'h33, 8'h44);
    clear_log();

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_slot", int'(out_slot), 0);
    resetn = 1'b1;
    tick();
    tick();
    chk("idle_no_start_busy", int'(busy), 0);

    // Basic pass; index 0 is the FETCH cycle right after start is sampled
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(15);
    chk("basic_rd_count", rd_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("basic_rd_addr%0d", k), qat(rd_q, k), k);
      chk($sformatf("basic_rd_cyc%0d", k), qat(rdi_q, k), 3 * k);
    end
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    chk("basic_xfer_count", xs_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("basic_slot%0d", k), qat(xs_q, k), k);
      chk($sformatf("basic_data%0d", k), qat(xd_q, k), exp_d[k]);
    end
    chk("basic_first_valid_cyc", qat(xi_q, 0), 2);
    chk("basic_done_count", dn_q.size(), 1);
    chk("basic_done_cyc", qat(dn_q, 0), 12);
    chk("basic_idle_after", int'(busy), 0);

    // Backpressure at slot 1
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(3);
    out_ready = 1'b0;
    observe(2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), int'(out_valid), 1);
      chk($sformatf("bp_data%0d", k), int'(out_data), 32'h22);
      chk($sformatf("bp_slot%0d", k), int'(out_slot), 1);
      tick();
    end
    out_ready = 1'b1;
    clear_log();
    observe(10);
    chk("bp_xfer_count", xs_q.size(), 3);
    chk("bp_xfer_slot_a", qat(xs_q, 0), 1);
    chk("bp_xfer_data_a", qat(xd_q, 0), 32'h22);
    chk("bp_xfer_cyc_a", qat(xi_q, 0), 0);
    chk("bp_xfer_slot_b", qat(xs_q, 1), 2);
    chk("bp_xfer_slot_c", qat(xs_q, 2), 3);
    chk("bp_done_count", dn_q.size(), 1);

    // Start pulsed again during CAPTURE of slot 0
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(1);
    start = 1'b1;
    observe(1);
    start = 1'b0;
    observe(16);
    chk("busy_start_xfers", xs_q.size(), 4);
    chk("busy_start_last_slot", qat(xs_q, 3), 3);
    chk("busy_start_dones", dn_q.size(), 1);
    chk("busy_start_done_cyc", qat(dn_q, 0), 12);
    chk("busy_start_idle", int'(busy), 0);

    // Start held high: second pass follows the IDLE cycle after FINISH
    clear_log();
    start = 1'b1;
    tick();
    observe(27);
    start = 1'b0;
    chk("b2b_xfers", xs_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_slot%0d", k), qat(xs_q, k), k % 4);
    end
    chk("b2b_dones", dn_q.size(), 2);
    chk("b2b_done1_cyc", qat(dn_q, 0), 12);
    chk("b2b_pass2_fetch_cyc", qat(rdi_q, 4), 14);
    chk("b2b_done2_cyc", qat(dn_q, 1), 26);
    tick();
    chk("b2b_stops", int'(busy), 0);

    // Zero bytes are delivered, not skipped
    load_bank(8'h00, 8'hFF, 8'h00, 8'h80);
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(15);
    exp_d = '{32'h00, 32'hFF, 32'h00, 32'h80};
    chk("zero_xfer_count", xs_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("zero_slot%0d", k), qat(xs_q, k), k);
      chk($sformatf("zero_data%0d", k), qat(xd_q, k), exp_d[k]);
    end
    chk("zero_done_count", dn_q.size(), 1);

    // Async reset during PRESENT of slot 2
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(8);
    out_ready = 1'b0;
    chk("mid_pre_valid", int'(out_valid), 1);
    chk("mid_pre_slot", int'(out_slot), 2);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_valid_now", int'(out_valid), 0);
    chk("mid_busy_now", int'(busy), 0);
    chk("mid_done_now", int'(done), 0);
    chk("mid_slot_now", int'(out_slot), 0);
    chk("mid_data_now", int'(out_data), 0);
    tick();
    tick();
    resetn    = 1'b1;
    out_ready = 1'b1;
    clear_log();
    observe(4);
    chk("mid_after_busy", int'(busy), 0);
    chk("mid_after_rd_en_count", rd_q.size(), 0);
    chk("mid_after_xfers", xs_q.size(), 0);

    // A fresh pass after reset starts from slot 0
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(15);
    chk("post_first_slot", qat(xs_q, 0), 0);
    chk("post_first_data", qat(xd_q, 0), 32'h00);
    chk("post_dones", dn_q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stored_byte_reader.md
Name: stored_byte_reader

Overview:
- Read-side counterpart to the team's 8-bit storage registers: walks a bank of NUM_SLOTS stored bytes in order, fetches each one, and hands it downstream over a valid/ready handshake.
- Consumers are the home-state display and status logic.
- Sits between the storage bank and any consumer that takes one byte at a time.

Parameters:
- NUM_SLOTS, 4, number of storage slots scanned per pass (2..16).
- ADDR_WIDTH, 2, width of slot index; must satisfy 2^ADDR_WIDTH >= NUM_SLOTS.
- DATA_WIDTH, 8, width of each stored value.

Ports:
- clock  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  pulse/level; begins a scan pass when in IDLE.
- rd_addr  output  ADDR_WIDTH  slot index presented to the storage bank.
- rd_en  output  1  high for exactly one cycle per slot fetch.
- rd_data  input  DATA_WIDTH  storage bank output; valid one cycle after rd_en.
- out_data  output  DATA_WIDTH  byte being handed downstream.
- out_slot  output  ADDR_WIDTH  slot index of out_data.
- out_valid  output  1  out_data/out_slot valid.
- out_ready  input  1  consumer accepts when high with out_valid.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last slot is accepted.

Behaviour:
- Interface decision: one clock, named clock; reset is asynchronous and active-low, named resetn.
- Reset (async, any time, including mid-pass):
  - State returns to IDLE.
  - Slot counter, rd_addr, out_data and out_slot become 0.
  - rd_en, out_valid, busy and done become 0.
  - No partial pass resumes after reset.
- States: IDLE, FETCH, CAPTURE, PRESENT, FINISH.
- IDLE:
  - busy = 0.
  - start = 1 -> FETCH with slot counter = 0.
  - start = 0 -> stay in IDLE.
- FETCH (1 cycle):
  - rd_addr = slot counter, rd_en = 1.
  - -> CAPTURE.
- CAPTURE (1 cycle):
  - Register rd_data into out_data and the slot counter into out_slot.
  - -> PRESENT.
- PRESENT:
  - out_valid = 1.
  - out_data and out_slot hold stable until transfer.
  - Transfer occurs on a rising edge with out_valid & out_ready.
  - On transfer, out_valid drops next cycle.
  - If slot counter == NUM_SLOTS-1 -> FINISH; else increment slot counter -> FETCH.
  - out_ready low -> stay; unbounded wait, no timeout.
- FINISH (1 cycle):
  - done = 1, slot counter cleared.
  - -> IDLE.
- Timing:
  - Best-case latency from start sampled to first out_valid is 3 cycles (FETCH, CAPTURE, then PRESENT).
  - Each subsequent slot costs 3 cycles plus any stall.
  - A full pass with out_ready tied high takes 3*NUM_SLOTS + 1 cycles after start.
- Boundary conditions:
  - start while busy is ignored; no queuing.
  - start held high continuously: a new pass begins on the cycle after FINISH, since IDLE samples start.
  - out_ready high outside PRESENT has no effect.
  - rd_data is ignored outside CAPTURE.
  - The slot counter never exceeds NUM_SLOTS-1; no wrap mid-pass.
  - rd_addr holds its last value outside FETCH; rd_en alone qualifies it.
  - Bytes equal to 0 (cleared or unselected slots) are delivered like any other value; there is no skipping.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=0, FETCH=1, CAPTURE=2, PRESENT=3, FINISH=4, 3 bits.
  - Default NUM_SLOTS, ADDR_WIDTH and DATA_WIDTH constants, reused by the storage bank.
- One sub-module is natural: slot_counter (load-zero, increment, last-slot flag).
- FSM and output register stay in the top module.

Test Plan:
- Reset mid-pass: assert resetn = 0 during PRESENT of slot 2 -> out_valid, busy and done go 0 immediately, not at the next edge. After release, stays IDLE until start.
- Basic pass: bank holds {0x11, 0x22, 0x33, 0x44}, out_ready tied 1, pulse start.
  - rd_en pulses at addr 0,1,2,3.
  - Outputs (slot,data) = (0,0x11), (1,0x22), (2,0x33), (3,0x44).
  - done pulses exactly once, 13 cycles after start.
- Backpressure: hold out_ready = 0 for 5 cycles at slot 1 -> out_valid stays 1, out_data = 0x22 and out_slot = 1 are stable. Exactly one transfer happens when out_ready rises.
- Start while busy: pulse start during CAPTURE of slot 0 -> the pass is unaffected; exactly 4 outputs and 1 done.
- Back-to-back: start held high -> second pass begins the cycle after FINISH. Output sequence repeats with slot 0 first, and done pulses once per pass.
- Zero data: bank {0x00, 0xFF, 0x00, 0x80} -> all four bytes are delivered in order, with no slots skipped.
